fetch_stage: RTL

- IF stage of the 5-stage MIPS pipeline: owns the PC register, the next-PC selection, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the stall/flush controls from the hazard unit and the redirect targets resolved in ID; produces the instruction and PC+4 consumed by ID.
- Tolerates multi-cycle instruction memory via a req/ready handshake, with a drain state for redirects that arrive while a fetch is outstanding.

---
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
// ----------------------------------------------------------------------------
// IF stage of the 5-stage MIPS pipeline. Owns the PC register, the next-PC
// selection, the instruction-memory req/ready handshake and the IF/ID
// pipeline register.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   i_pc_keep             hold PC this cycle (hazard unit)
//   i_IF_ID_keep          hold IF/ID register this cycle
//   i_IF_ID_flush         load a bubble into IF/ID this cycle
//   i_branch_final        taken branch resolved in ID
//   i_branch_target       branch target address
//   i_jump                00 none, 01 j/jal, 10 jr/jalr (11 = none)
//   i_jump_target         j/jal target
//   i_jr_target           jr/jalr register target
//   o_imem_req            fetch request valid
//   o_imem_addr           fetch address (always the current PC)
//   i_imem_ready          i_imem_rdata valid for o_imem_addr this cycle
//   i_imem_rdata          fetched instruction
//   o_IF_ID_instruction   instruction to ID
//   o_IF_ID_pc_plus4      PC+4 of that instruction
//   o_IF_ID_valid         1 = real instruction, 0 = bubble
//   o_pc                  current PC (debug/trace)
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pc_keep,
  input  logic        i_IF_ID_keep,
  input  logic        i_IF_ID_flush,
  input  logic        i_branch_final,
  input  logic [31:0] i_branch_target,
  input  logic [1:0]  i_jump,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_IF_ID_instruction,
  output logic [31:0] o_IF_ID_pc_plus4,
  output logic        o_IF_ID_valid,
  output logic [31:0] o_pc
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pending, pending_next;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target;
  logic        fetch_accept;

  assign pc_plus4 = pc + 32'd4;

  // A hazard stall suppresses any redirect; ID re-evaluates the control
  // transfer next cycle once the stall clears. Jump code 11 counts as none.
  assign redirect = !i_pc_keep &&
                    (i_branch_final || i_jump == 2'b01 || i_jump == 2'b10);

  // Redirect target selection: a resolved branch beats any jump.
  always_comb begin
    target = i_jump_target;
    if (i_branch_final)
      target = i_branch_target;
    else if (i_jump == 2'b10)
      target = i_jr_target;
  end

  // An instruction is accepted into IF/ID only when it is the answer to a
  // request that is not being thrown away by a stall or a redirect.
  assign fetch_accept = (state == S_FETCH) && i_imem_ready &&
                        !i_pc_keep && !redirect;

  assign o_imem_req  = (state != S_BOOT);
  assign o_imem_addr = pc;
  assign o_pc        = pc;

  // Next-state / next-PC logic. A redirect that arrives while a fetch is
  // still outstanding is parked in 'pending' so the address presented to
  // memory stays stable until the in-flight request completes (S_DRAIN).
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    case (state)
      S_BOOT: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_pc_keep) begin
          pc_next = pc;
        end else if (redirect && i_imem_ready) begin
          pc_next = target;
        end else if (redirect) begin
          pending_next = target;
          state_next   = S_DRAIN;
        end else if (i_imem_ready) begin
          pc_next = pc_plus4;
        end
      end
      S_DRAIN: begin
        if (i_imem_ready) begin
          pc_next    = redirect ? target : pending;
          state_next = S_FETCH;
        end else if (redirect) begin
          pending_next = target;
        end
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  // PC, FSM state and parked redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_BOOT;
      pc      <= RESET_PC;
      pending <= 32'd0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pending <= pending_next;
    end
  end

  // IF/ID pipeline register: keep beats flush; anything that is not an
  // accepted fetch becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_IF_ID_instruction <= NOP_INSTR;
      o_IF_ID_pc_plus4    <= 32'd0;
      o_IF_ID_valid       <= 1'b0;
    end else if (i_IF_ID_keep) begin
      o_IF_ID_instruction <= o_IF_ID_instruction;
      o_IF_ID_pc_plus4    <= o_IF_ID_pc_plus4;
      o_IF_ID_valid       <= o_IF_ID_valid;
    end else if (!i_IF_ID_flush && fetch_accept) begin
      o_IF_ID_instruction <= i_imem_rdata;
      o_IF_ID_pc_plus4    <= pc_plus4;
      o_IF_ID_valid       <= 1'b1;
    end else begin
      o_IF_ID_instruction <= NOP_INSTR;
      o_IF_ID_pc_plus4    <= 32'd0;
      o_IF_ID_valid       <= 1'b0;
    end
  end

endmodule
